// File: rtl/lstm_uart_ctrl.sv
// Frame sequencer between the UART and the LSTM datapath: packs received bytes
// into D_WL-bit words, fills the input buffer, runs one inference, and returns the class.
module lstm_uart_ctrl #(
  parameter int INPUT_SIZE  = 20,
  parameter int TIME_STEP   = 3,
  parameter int CLASS_NUM   = 2,
  parameter int D_WL        = 24,
  parameter int TIMEOUT_CYC = 200000,
  localparam int NB = (D_WL + 7) / 8,
  localparam int NW = INPUT_SIZE * TIME_STEP,
  localparam int AW = (NW > 1) ? $clog2(NW) : 1,
  localparam int CW = (CLASS_NUM > 2) ? $clog2(CLASS_NUM) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_finish,
  output logic [7:0]      tx_data,
  output logic            tx_en,
  input  logic            tx_finish,
  output logic            buf_we,
  output logic [AW-1:0]   buf_addr,
  output logic [D_WL-1:0] buf_wdata,
  output logic            net_start,
  input  logic            net_done,
  input  logic [CW-1:0]   net_class,
  output logic            o_valid,
  output logic [CW-1:0]   result,
  output logic            frame_err,
  output logic            busy
);

  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int GW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_START, S_WAIT, S_SEND, S_TXWAIT
  } state_t;

  state_t state, state_nx;

  logic [BW-1:0]   byte_cnt;
  logic [AW-1:0]   word_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [2:0]      txw_cnt;
  logic            tx_low_seen;
  // Only the bytes still to be kept need storing; D_WL must exceed 8.
  logic [D_WL-9:0] shift_q;
  logic [D_WL-1:0] shift_nx;

  logic last_wr;
  logic byte_acc;
  logic word_done;
  logic gap_hit;

  assign shift_nx  = {shift_q, rx_data};
  // The final word's write strobe is what releases the frame to the network.
  assign last_wr   = buf_we && (buf_addr == AW'(NW - 1));
  assign byte_acc  = rx_finish && ((state == S_IDLE) || ((state == S_RECV) && !last_wr));
  assign word_done = byte_acc && (byte_cnt == BW'(NB - 1));
  // A byte arriving on the timeout cycle wins, so the hit requires rx_finish low.
  assign gap_hit   = (state == S_RECV) && !last_wr && !rx_finish &&
                     (gap_cnt == GW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nx  = state;
    net_start = 1'b0;
    frame_err = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (rx_finish) state_nx = S_RECV;
      S_RECV: begin
        if (last_wr) begin
          state_nx = S_START;
        end else if (gap_hit) begin
          frame_err = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      S_START: begin
        net_start = 1'b1;
        state_nx  = S_WAIT;
      end
      S_WAIT:  if (net_done) state_nx = S_SEND;
      S_SEND:  if (tx_finish) state_nx = S_TXWAIT;
      S_TXWAIT: begin
        // Either the transmitter dropped busy and came back, or it never reacted.
        if (tx_finish && (tx_low_seen || (txw_cnt == 3'd4))) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // update together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, including the data-only ones, is reset so the
    // outputs are defined from the first cycle after reset.
    if (!rst_n) begin
      byte_cnt    <= '0;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      shift_q     <= '0;
      txw_cnt     <= '0;
      tx_low_seen <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      o_valid     <= 1'b0;
      result      <= '0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
    end else begin
      buf_we  <= 1'b0;
      o_valid <= 1'b0;
      tx_en   <= 1'b0;

      if (byte_acc) begin
        shift_q <= shift_nx[D_WL-9:0];
        if (word_done) begin
          byte_cnt  <= '0;
          buf_we    <= 1'b1;
          buf_addr  <= word_cnt;
          buf_wdata <= shift_nx;
          word_cnt  <= (word_cnt == AW'(NW - 1)) ? '0 : word_cnt + AW'(1);
        end else begin
          byte_cnt <= byte_cnt + BW'(1);
        end
      end

      if (gap_hit) begin
        byte_cnt <= '0;
        word_cnt <= '0;
      end

      gap_cnt <= ((state == S_RECV) && !rx_finish && !gap_hit) ? gap_cnt + GW'(1) : '0;

      if ((state == S_WAIT) && net_done) begin
        result  <= net_class;
        o_valid <= 1'b1;
      end

      if ((state == S_SEND) && tx_finish) begin
        tx_data <= 8'(result);
        tx_en   <= 1'b1;
      end

      if (state == S_TXWAIT) begin
        if (txw_cnt != 3'd4) txw_cnt <= txw_cnt + 3'd1;
        if (!tx_finish) tx_low_seen <= 1'b1;
      end else begin
        txw_cnt     <= '0;
        tx_low_seen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lstm_uart_ctrl.sv
// Bench for lstm_uart_ctrl: table of frame scenarios with random payloads, checked
// against the intended word list, latencies and class result; plus reset and timeout sequences.
module tb_lstm_uart_ctrl;

  localparam int TO = 50;
  localparam int NWORDS = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_finish = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_finish = 1'b1;
  logic        buf_we;
  logic [5:0]  buf_addr;
  logic [23:0] buf_wdata;
  logic        net_start;
  logic        net_done = 1'b0;
  logic [0:0]  net_class = '0;
  logic        o_valid;
  logic [0:0]  result;
  logic        frame_err;
  logic        busy;

  lstm_uart_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_finish(rx_finish),
    .tx_data(tx_data), .tx_en(tx_en), .tx_finish(tx_finish),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .net_start(net_start), .net_done(net_done), .net_class(net_class),
    .o_valid(o_valid), .result(result), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Event capture, sampled mid-cycle on the falling edge.
  logic [5:0]  wr_addr_q [$];
  logic [23:0] wr_data_q [$];
  int we_cyc = -1, start_cnt = 0, start_cyc = -1, ov_cnt = 0, ov_cyc = -1;
  int tx_cnt = 0, fe_cnt = 0, fe_cyc = -1;
  logic [7:0] tx_val = '0;

  always @(negedge clk) begin
    if (buf_we) begin
      wr_addr_q.push_back(buf_addr);
      wr_data_q.push_back(buf_wdata);
      we_cyc = cyc;
    end
    if (net_start) begin start_cnt++; start_cyc = cyc; end
    if (o_valid)   begin ov_cnt++;    ov_cyc = cyc;    end
    if (tx_en)     begin tx_cnt++;    tx_val = tx_data; end
    if (frame_err) begin fe_cnt++;    fe_cyc = cyc;    end
  end

  // Transmitter model: goes busy the cycle after a request, idle again 6 cycles later.
  bit tx_auto = 1'b1;
  initial forever begin
    @(negedge clk);
    if (tx_en && tx_auto) begin
      @(posedge clk); #1 tx_finish = 1'b0;
      repeat (6) @(posedge clk);
      #1 tx_finish = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [23:0] frame_w [NWORDS];
  int last_rx = 0;

  task automatic send_byte(input logic [7:0] b);
    rx_data   = b;
    rx_finish = 1'b1;
    last_rx   = cyc;
    tick(1);
    rx_finish = 1'b0;
  endtask

  // Bytes go out MSB first, three per word; random idle gaps stay well under TO.
  task automatic send_words(input int n_bytes);
    for (int i = 0; i < n_bytes; i++) begin
      send_byte(frame_w[i / 3][8 * (2 - i % 3) +: 8]);
      if (i < n_bytes - 1) tick($urandom_range(0, 3));
    end
  endtask

  typedef struct {
    bit         ramp;
    logic       cls;
    int         done_dly;
    bit         inject;
    bit         hold;
    bit         early;
    logic [7:0] exp_tx;
    logic       exp_res;
  } frame_vec_t;

  frame_vec_t vecs [5];
  logic prev_res = 1'b0;

  task automatic run_frame(input int idx);
    frame_vec_t v;
    int s0, o0, t0, done_cyc, budget;
    v = vecs[idx];
    for (int k = 0; k < NWORDS; k++)
      frame_w[k] = v.ramp ? 24'h010203 + 24'(k) : 24'($urandom);
    wr_addr_q.delete();
    wr_data_q.delete();
    s0 = start_cnt; o0 = ov_cnt; t0 = tx_cnt;
    check($sformatf("f%0d result held", idx), 32'(result), 32'(prev_res));
    if (v.hold) begin tx_auto = 1'b0; tx_finish = 1'b0; end

    send_words(3 * NWORDS);
    if (v.early) begin
      tick(1);
      net_done  = 1'b1;
      net_class = ~v.cls;
      tick(1);
      net_done  = 1'b0;
    end
    budget = 0;
    while (start_cnt == s0 && budget < 20) begin tick(1); budget++; end
    check($sformatf("f%0d net_start count", idx), 32'(start_cnt - s0), 32'd1);
    check($sformatf("f%0d net_start latency", idx), 32'(start_cyc - last_rx), 32'd2);
    check($sformatf("f%0d last buf_we latency", idx), 32'(we_cyc - last_rx), 32'd1);
    check($sformatf("f%0d write count", idx), 32'(wr_addr_q.size()), 32'(NWORDS));
    for (int k = 0; k < NWORDS && k < wr_addr_q.size(); k++) begin
      check($sformatf("f%0d wr%0d addr", idx, k), 32'(wr_addr_q[k]), 32'(k));
      check($sformatf("f%0d wr%0d data", idx, k), 32'(wr_data_q[k]), 32'(frame_w[k]));
    end

    if (v.inject) begin
      for (int j = 0; j < 5; j++) begin send_byte(8'($urandom)); tick(1); end
      check($sformatf("f%0d writes during WAIT", idx), 32'(wr_addr_q.size()), 32'(NWORDS));
    end

    while (cyc < start_cyc + v.done_dly) tick(1);
    net_done  = 1'b1;
    net_class = v.cls;
    done_cyc  = cyc;
    tick(1);
    net_done  = 1'b0;
    net_class = 1'($urandom);

    if (v.hold) begin
      tick(100);
      check($sformatf("f%0d tx_en while tx busy", idx), 32'(tx_cnt - t0), 32'd0);
      check($sformatf("f%0d busy while tx held", idx), 32'(busy), 32'd1);
      tx_finish = 1'b1;
    end
    budget = 0;
    while (tx_cnt == t0 && budget < 20) begin tick(1); budget++; end
    budget = 0;
    while (busy && budget < 40) begin tick(1); budget++; end
    tx_auto = 1'b1;
    tick(1);

    check($sformatf("f%0d o_valid count", idx), 32'(ov_cnt - o0), 32'd1);
    check($sformatf("f%0d o_valid latency", idx), 32'(ov_cyc - done_cyc), 32'd1);
    check($sformatf("f%0d result", idx), 32'(result), 32'(v.exp_res));
    check($sformatf("f%0d tx_en count", idx), 32'(tx_cnt - t0), 32'd1);
    check($sformatf("f%0d tx_data", idx), 32'(tx_val), 32'(v.exp_tx));
    check($sformatf("f%0d busy after frame", idx), 32'(busy), 32'd0);
    prev_res = v.exp_res;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " buf_we"},    32'(buf_we),    32'd0);
    check({tag, " buf_addr"},  32'(buf_addr),  32'd0);
    check({tag, " buf_wdata"}, 32'(buf_wdata), 32'd0);
    check({tag, " net_start"}, 32'(net_start), 32'd0);
    check({tag, " o_valid"},   32'(o_valid),   32'd0);
    check({tag, " result"},    32'(result),    32'd0);
    check({tag, " tx_en"},     32'(tx_en),     32'd0);
    check({tag, " tx_data"},   32'(tx_data),   32'd0);
    check({tag, " frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    int fe0;
    //          ramp cls dly inj hold early exp_tx exp_res
    vecs[0] = '{1'b1, 1'b1, 37, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 40, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1};
    vecs[3] = '{1'b0, 1'b0,  6, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 1'b1,  9, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1};

    #3 check_idle_outputs("reset");
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Reset in the middle of a frame, then a clean ramp frame must land at 0..59.
    for (int k = 0; k < NWORDS; k++) frame_w[k] = 24'($urandom);
    send_words(50);
    check("mid-frame busy", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1 check_idle_outputs("mid-frame reset");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    run_frame(0);

    // Abandoned frame: 100 bytes then silence.
    for (int k = 0; k < NWORDS; k++) frame_w[k] = 24'($urandom);
    wr_addr_q.delete();
    wr_data_q.delete();
    fe0 = fe_cnt;
    send_words(100);
    tick(TO + 10);
    check("timeout frame_err count", 32'(fe_cnt - fe0), 32'd1);
    check("timeout frame_err latency", 32'(fe_cyc - last_rx), 32'(TO));
    check("timeout busy", 32'(busy), 32'd0);
    check("timeout write count", 32'(wr_addr_q.size()), 32'd33);
    if (wr_addr_q.size() == 33) begin
      check("timeout last addr", 32'(wr_addr_q[32]), 32'd32);
      check("timeout last data", 32'(wr_data_q[32]), 32'(frame_w[32]));
    end

    for (int i = 1; i < 5; i++) run_frame(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
